iotdf_byte_tx: RTL
==================

# iotdf_byte_tx

Transmit-side serializer for the IoT data filter byte stream. Accepts 128-bit IoT words from an upstream valid/ready source, buffers them in a small FIFO, and drives the 8-bit `iot_in` / `in_en` / `fn_sel` stream that the filter consumes. It holds a fixed function code for a whole stream and keeps the 16 bytes of each word on consecutive cycles. It also flags any gap between words inside a stream, because the receiver's 128-cycle counter free-runs after the first byte.

## Interface
- `DEPTH`, 2: FIFO entries (power of 2, ≥2)
- `WORD_W`, 128: word width; fixed at 16 bytes
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `s_valid`  in  1  upstream word valid
- `s_ready`  out  1  FIFO can accept (`count < DEPTH`)
- `s_data`  in  128  IoT word
- `s_last`  in  1  word is final of its stream
- `cfg_fn`  in  3  function code for next stream (1..7)
- `busy`  in  1  receiver backpressure, sampled only at word boundaries
- `in_en`  out  1  byte valid to receiver (registered)
- `iot_in`  out  8  byte to receiver (registered)
- `fn_sel`  out  3  function code held for the stream (registered)
- `underrun`  out  1  sticky: FIFO ran empty mid-stream
- `words_sent`  out  16  count of words fully transmitted, wraps at 2^16

## Operation
- FIFO push when `s_valid && s_ready`. Each entry holds {`s_last`, `s_data`}.
- Simultaneous push and pop are legal when not full. There is no full-FIFO bypass.
- Byte order: byte k of a word = `s_data[8k+7:8k]`, sent k = 0..15 (LSB byte first). The receiver therefore reassembles the last byte as bits [127:120].
- FSM states: IDLE, SEND.
  - IDLE → SEND when FIFO is non-empty and `busy` = 0. On this transition, `fn_sel` latches `cfg_fn` and `byte_cnt` is cleared to 0.
  - SEND: each cycle drive `in_en` = 1 and `iot_in` = head byte[`byte_cnt`], then increment `byte_cnt`.
  - At `byte_cnt` = 15: pop the head and increment `words_sent`. Then:
    - If the head was `last`: go to IDLE.
    - Else if the FIFO still holds another word (count after pop ≥ 1, including a same-cycle push) and `busy` = 0: continue SEND with `byte_cnt` = 0.
    - Else: go to IDLE with `underrun` ← 1. While `busy` holds the stream, `fn_sel` is retained.
- `busy` asserted mid-word is ignored; a word, once started, always completes.
- `cfg_fn` changes during a stream are ignored until the next IDLE → SEND transition.
- `underrun` is cleared only by `rst`.

## Timing
- Reset values:
  - `in_en` = 0, `iot_in` = 0, `fn_sel` = 0, `underrun` = 0, `words_sent` = 0
  - FIFO empty, so `s_ready` = 1
  - FSM in IDLE
- Latency: a word pushed into an empty FIFO at edge N, with `busy` = 0, gives `in_en` = 1 / byte 0 after edge N+1, and byte 15 after edge N+16.
- Back-to-back: if the next word is present by the cycle of byte 15, its byte 0 follows the next edge, with zero gap.
- `s_ready` deasserts the cycle after the FIFO reaches `DEPTH`. It reasserts the cycle after a pop (registered count).
- `words_sent` updates on the edge that outputs byte 15.
- `rst` mid-word: everything returns to reset values immediately; the partial word is discarded.
- `busy` = 1 at a boundary: `in_en` drops to 0 on the next edge and `iot_in` holds its last value.

## Structure
- Shared package `iotdf_pkg`:
  - `FN_MAX`=1, `FN_MIN`=2, `FN_AVG`=3, `FN_EXT`=4, `FN_EXC`=5, `FN_PMAX`=6, `FN_PMIN`=7
  - `BYTES_PER_WORD`=16
  - `WORDS_PER_ROUND`=8
  - state encoding
- Sub-module `iotdf_word_fifo`:
  - Parameters `DEPTH`, `WIDTH` = 129.
  - Interface: push/pop/full/empty/count.
- The top holds the FSM, `byte_cnt`, output registers and counters.

## Test plan
- Push 128'h0F0E0D0C_0B0A0908_07060504_03020100 with `s_last` = 1 and `cfg_fn` = 3 → 16 consecutive `in_en` cycles carrying bytes 00,01,…,0F. Then `fn_sel` = 3 throughout, `words_sent` = 1, `in_en` = 0 after, `underrun` = 0.
- Stream 8 words, `s_valid` held high, last on word 8 → 128 contiguous `in_en` cycles, `s_ready` toggling as the 2-deep FIFO fills and drains, `words_sent` = 8, no underrun.
- Push word 1 (not last), then delay word 2 until 5 cycles after word 1's byte 15 → `underrun` = 1 after byte 15, `in_en` gap, then word 2 sent.
- Assert `busy` during byte 7 of word 1 → word 1 completes. With `busy` held at the boundary, `in_en` = 0 until `busy` drops; word 2 starts the edge after.
- Change `cfg_fn` 1 → 6 mid-stream → `fn_sel` stays 1 until the stream ends. The next stream shows 6.
- Assert `rst` at byte 9 → `in_en`, `iot_in` and `fn_sel` are 0 immediately, the FIFO is empty, `s_ready` = 1, and `words_sent` = 0.

Source files
------------

// File: rtl/iotdf_pkg.sv
// Shared definitions for the IoT data filter byte-stream path:
// function codes, word geometry, transmit FSM encoding and byte extraction.
package iotdf_pkg;

    localparam logic [2:0] FN_MAX  = 3'd1;
    localparam logic [2:0] FN_MIN  = 3'd2;
    localparam logic [2:0] FN_AVG  = 3'd3;
    localparam logic [2:0] FN_EXT  = 3'd4;
    localparam logic [2:0] FN_EXC  = 3'd5;
    localparam logic [2:0] FN_PMAX = 3'd6;
    localparam logic [2:0] FN_PMIN = 3'd7;

    localparam int BYTES_PER_WORD  = 16;
    localparam int WORDS_PER_ROUND = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    // Byte idx of a word, LSB byte first.
    function automatic logic [7:0] word_byte(input logic [8*BYTES_PER_WORD-1:0] word,
                                             input logic [3:0]                  idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/iotdf_byte_tx_if.sv
// Upstream valid/ready word channel feeding the byte transmitter.
interface iotdf_byte_tx_if #(
    parameter int WORD_W = 128
);
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/iotdf_word_fifo.sv
// Small synchronous FIFO holding {last, word} entries; registered occupancy count.
module iotdf_word_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 129
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/iotdf_byte_tx.sv
// Word-to-byte serializer for the IoT data filter. FSM states:
// IDLE | no word in flight, waiting for a queued word and busy low;  SEND | emitting bytes of the head word
module iotdf_byte_tx
    import iotdf_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int WORD_W = 128
) (
    input  logic                clk,
    input  logic                rst,
    iotdf_byte_tx_if.slave      up,
    input  logic [2:0]          cfg_fn,
    input  logic                busy,
    output logic                in_en,
    output logic [7:0]          iot_in,
    output logic [2:0]          fn_sel,
    output logic                underrun,
    output logic [15:0]         words_sent
);
    localparam int         CW        = $clog2(DEPTH) + 1;
    localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_WORD - 1);

    tx_state_e         state_q, state_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic              in_en_q, in_en_d;
    logic [7:0]        iot_in_q, iot_in_d;
    logic [2:0]        fn_sel_q, fn_sel_d;
    logic              underrun_q, underrun_d;
    logic [15:0]       words_sent_q, words_sent_d;

    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [WORD_W-1:0] head_data;
    logic              head_last;
    logic              more_after_pop;

    assign push       = up.s_valid && up.s_ready;
    assign up.s_ready = !fifo_full;

    iotdf_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({up.s_last, up.s_data}),
        .pop   (pop),
        .rdata ({head_last, head_data}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A same-cycle push counts as the follow-on word.
    assign more_after_pop = (fifo_count > CW'(1)) || push;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        in_en_d      = 1'b0;
        iot_in_d     = iot_in_q;
        fn_sel_d     = fn_sel_q;
        underrun_d   = underrun_q;
        words_sent_d = words_sent_q;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Byte 0 is registered on the entry edge, so SEND resumes at byte 1.
                if (!fifo_empty && !busy) begin
                    state_d    = ST_SEND;
                    fn_sel_d   = cfg_fn;
                    in_en_d    = 1'b1;
                    iot_in_d   = word_byte(head_data, 4'd0);
                    byte_cnt_d = 4'd1;
                end
            end
            ST_SEND: begin
                in_en_d    = 1'b1;
                iot_in_d   = word_byte(head_data, byte_cnt_q);
                byte_cnt_d = byte_cnt_q + 4'd1;
                if (byte_cnt_q == LAST_BYTE) begin
                    pop          = 1'b1;
                    words_sent_d = words_sent_q + 16'd1;
                    byte_cnt_d   = 4'd0;
                    if (head_last) begin
                        state_d = ST_IDLE;
                    end else if (more_after_pop && !busy) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d    = ST_IDLE;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            in_en_q      <= 1'b0;
            iot_in_q     <= '0;
            fn_sel_q     <= '0;
            underrun_q   <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            in_en_q      <= in_en_d;
            iot_in_q     <= iot_in_d;
            fn_sel_q     <= fn_sel_d;
            underrun_q   <= underrun_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign in_en      = in_en_q;
    assign iot_in     = iot_in_q;
    assign fn_sel     = fn_sel_q;
    assign underrun   = underrun_q;
    assign words_sent = words_sent_q;
endmodule
